// File: rtl/snoop_bus_controller.sv
// Snoopy MSI coherence controller and single-port RAM arbiter for CPUS data caches.
// Round-robin grants one cache at a time; misses are served cache-to-cache or from RAM.
module snoop_bus_controller #(
  parameter int unsigned CPUS  = 2,
  parameter int unsigned WORDS = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [CPUS-1:0]     cctrans,
  input  logic [CPUS-1:0]     ccwrite,
  input  logic [CPUS*AW-1:0]  daddr,
  input  logic [CPUS*DW-1:0]  dstore,
  output logic [CPUS-1:0]     dwait,
  output logic [CPUS*DW-1:0]  dload,
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output logic [CPUS*AW-1:0]  ccsnoopaddr,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [AW-1:0]       ramaddr,
  output logic [DW-1:0]       ramstore,
  input  logic [DW-1:0]       ramload,
  input  logic                ramwait
);

  localparam int unsigned   IW       = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned   BW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned   OFS      = $clog2(WORDS) + 2;
  localparam logic [AW-1:0] LoMask   = AW'((1 << OFS) - 1);
  localparam logic [IW-1:0] LastCpu  = IW'(CPUS - 1);
  localparam logic [BW-1:0] LastBeat = BW'(WORDS - 1);

  typedef enum logic [2:0] {StIdle, StSnoop, StXfer, StWbk, StInval} state_e;
  typedef enum logic [1:0] {ClsWm, ClsRm, ClsWb, ClsInv} cls_e;

  state_e         r_state, w_state_n;
  cls_e           r_cls, w_cls_n, w_gnt_cls;
  logic [IW-1:0]  r_req, w_req_n;
  logic [IW-1:0]  r_sup, w_sup_n;
  logic [IW-1:0]  r_ptr, w_ptr_n;
  logic [BW-1:0]  r_beat, w_beat_n;
  logic           r_hit, w_hit_n;

  logic [CPUS-1:0] w_any;
  logic            w_gnt_vld;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_hit;
  logic [IW-1:0]   w_sup;
  logic [IW-1:0]   w_ptr_inc;
  logic            w_last;
  logic [AW-1:0]   w_req_addr, w_base, w_beat_addr;
  logic [DW-1:0]   w_req_data, w_sup_data;

  assign w_any       = dREN | dWEN | cctrans;
  assign w_req_addr  = daddr[r_req*AW +: AW];
  assign w_req_data  = dstore[r_req*DW +: DW];
  assign w_sup_data  = dstore[r_sup*DW +: DW];
  assign w_base      = w_req_addr & ~LoMask;
  assign w_beat_addr = w_base + (AW'(r_beat) << 2);
  assign w_ptr_inc   = (r_req == LastCpu) ? '0 : r_req + 1'b1;
  assign w_last      = (r_beat == LastBeat);

  // Scan downward so the candidate closest to r_ptr is written last and wins.
  always_comb begin
    logic [IW-1:0] w_cand;
    w_cand    = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = int'(CPUS) - 1; k >= 0; k--) begin
      w_cand = IW'((int'(r_ptr) + k) % int'(CPUS));
      if (w_any[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    if (dREN[w_gnt_idx] && cctrans[w_gnt_idx]) begin
      w_gnt_cls = ClsWm;
    end else if (dREN[w_gnt_idx]) begin
      w_gnt_cls = ClsRm;
    end else if (dWEN[w_gnt_idx]) begin
      w_gnt_cls = ClsWb;
    end else begin
      w_gnt_cls = ClsInv;
    end
  end

  // Several dirty responders is a protocol error; the lowest index supplies.
  always_comb begin
    w_hit = 1'b0;
    w_sup = '0;
    for (int k = int'(CPUS) - 1; k >= 0; k--) begin
      if (IW'(k) != r_req && ccwrite[k]) begin
        w_hit = 1'b1;
        w_sup = IW'(k);
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cls_n   = r_cls;
    w_req_n   = r_req;
    w_sup_n   = r_sup;
    w_hit_n   = r_hit;
    w_ptr_n   = r_ptr;
    w_beat_n  = r_beat;
    unique case (r_state)
      StIdle: begin
        if (w_gnt_vld) begin
          w_req_n   = w_gnt_idx;
          w_cls_n   = w_gnt_cls;
          w_state_n = (w_gnt_cls == ClsWb) ? StWbk : StSnoop;
        end
      end
      StSnoop: begin
        w_hit_n   = w_hit;
        w_sup_n   = w_sup;
        w_state_n = (r_cls == ClsInv) ? StInval : StXfer;
      end
      StXfer, StWbk: begin
        if (!ramwait) begin
          if (w_last) begin
            w_beat_n  = '0;
            w_ptr_n   = w_ptr_inc;
            w_state_n = StIdle;
          end else begin
            w_beat_n = r_beat + 1'b1;
          end
        end
      end
      StInval: begin
        w_ptr_n   = w_ptr_inc;
        w_state_n = StIdle;
      end
      default: w_state_n = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= StIdle;
      r_cls   <= ClsWm;
      r_req   <= '0;
      r_sup   <= '0;
      r_hit   <= 1'b0;
      r_ptr   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cls   <= w_cls_n;
      r_req   <= w_req_n;
      r_sup   <= w_sup_n;
      r_hit   <= w_hit_n;
      r_ptr   <= w_ptr_n;
      r_beat  <= w_beat_n;
    end
  end

  always_comb begin
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (r_state != StIdle) begin
      for (int j = 0; j < int'(CPUS); j++) begin
        if (IW'(j) != r_req) ccsnoopaddr[j*AW +: AW] = w_base;
      end
    end
    unique case (r_state)
      StSnoop: begin
        for (int j = 0; j < int'(CPUS); j++) begin
          if (IW'(j) != r_req) ccwait[j] = 1'b1;
        end
      end
      StXfer: begin
        ramaddr = w_beat_addr;
        if (r_hit) begin
          // Dirty owner feeds the requester and RAM in the same beat.
          ccwait[r_sup]          = 1'b1;
          dload[r_req*DW +: DW]  = w_sup_data;
          ramWEN                 = 1'b1;
          ramstore               = w_sup_data;
          dwait[r_sup]           = ramwait;
          dwait[r_req]           = ramwait;
        end else begin
          ramREN                 = 1'b1;
          dload[r_req*DW +: DW]  = ramload;
          dwait[r_req]           = ramwait;
        end
        if (r_cls == ClsWm) begin
          for (int j = 0; j < int'(CPUS); j++) begin
            if (IW'(j) != r_req) ccinv[j] = 1'b1;
          end
        end
      end
      StWbk: begin
        ramWEN       = 1'b1;
        ramaddr      = w_beat_addr;
        ramstore     = w_req_data;
        dwait[r_req] = ramwait;
      end
      StInval: begin
        for (int j = 0; j < int'(CPUS); j++) begin
          if (IW'(j) != r_req) ccinv[j] = 1'b1;
        end
        dwait[r_req] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
